boot_controller: RTL and testbench

Sequences the single-cycle RISC-V core: holds the core in reset, streams a program into instruction memory through the instruction write port (`instr_in`, `instr_wr_addr`, `instr_wr_en`), then releases the core for a bounded or unbounded run and halts it. It sits between a program source (testbench or host link) and the core top, and owns the core's reset and the instruction-memory write port.

---
 rtl/boot_controller.sv | 152 +++++++++++++++
 tb/tb_boot_controller.sv | 363 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/boot_controller.sv
// boot_controller: owns core reset and the instruction-memory write port.
// Loads a program word by word, flushes, runs the core, then halts it.
module boot_controller #(
    parameter int WIDTH = 32,
    parameter int SIZE = 128,
    localparam int LOGSIZE = $clog2(SIZE)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               load_start,
    input  logic [LOGSIZE:0]   load_count,
    input  logic [WIDTH-1:0]   word_in,
    input  logic               word_valid,
    output logic               word_ready,
    input  logic [31:0]        run_cycles,
    input  logic               stop,
    output logic [WIDTH-1:0]   instr_in,
    output logic [LOGSIZE+1:0] instr_wr_addr,
    output logic               instr_wr_en,
    output logic               core_reset,
    output logic               busy,
    output logic               done,
    output logic               error,
    output logic [31:0]        cycle_count
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_FLUSH,
        S_RUN,
        S_HALT
    } state_e;

    localparam logic [LOGSIZE:0] SIZE_W = (LOGSIZE + 1)'(SIZE);
    localparam logic [LOGSIZE:0] ONE_W  = (LOGSIZE + 1)'(1);

    state_e               state_q, state_d;
    logic [LOGSIZE:0]     count_q, count_d;
    logic [LOGSIZE-1:0]   index_q, index_d;
    logic                 flush_q, flush_d;
    logic [WIDTH-1:0]     instr_q, instr_d;
    logic [LOGSIZE+1:0]   addr_q, addr_d;
    logic                 wr_en_q, wr_en_d;
    logic                 error_q, error_d;
    logic [31:0]          cyc_q, cyc_d;

    logic load_ok;
    logic accept;
    logic last_word;
    logic run_expired;

    // Register all controller state; reset wins over everything, dropping any pending write.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            count_q <= '0;
            index_q <= '0;
            flush_q <= 1'b0;
            instr_q <= '0;
            addr_q  <= '0;
            wr_en_q <= 1'b0;
            error_q <= 1'b0;
            cyc_q   <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            index_q <= index_d;
            flush_q <= flush_d;
            instr_q <= instr_d;
            addr_q  <= addr_d;
            wr_en_q <= wr_en_d;
            error_q <= error_d;
            cyc_q   <= cyc_d;
        end
    end

    // Next-state, write-port staging and run counter.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        index_d = index_q;
        flush_d = flush_q;
        instr_d = instr_q;
        addr_d  = addr_q;
        wr_en_d = 1'b0;
        error_d = error_q;
        cyc_d   = cyc_q;

        load_ok     = (load_count != '0) && (load_count <= SIZE_W);
        accept      = word_valid && (state_q == S_LOAD);
        last_word   = ({1'b0, index_q} == (count_q - ONE_W));
        run_expired = (run_cycles != 32'd0) &&
                      (cyc_q == (run_cycles - 32'd1));

        unique case (state_q)
            S_IDLE, S_HALT: begin
                if (load_start) begin
                    if (load_ok) begin
                        count_d = load_count;
                        index_d = '0;
                        error_d = 1'b0;
                        state_d = S_LOAD;
                    end else begin
                        error_d = 1'b1;
                    end
                end
            end
            S_LOAD: begin
                if (accept) begin
                    instr_d = word_in;
                    addr_d  = {index_q, 2'b00};
                    wr_en_d = 1'b1;
                    index_d = index_q + 1'b1;
                    if (last_word) begin
                        state_d = S_FLUSH;
                        flush_d = 1'b0;
                    end
                end
            end
            S_FLUSH: begin
                if (flush_q) begin
                    state_d = S_RUN;
                    cyc_d   = '0;
                end else begin
                    flush_d = 1'b1;
                end
            end
            S_RUN: begin
                cyc_d = cyc_q + 32'd1;
                if (stop || run_expired) begin
                    state_d = S_HALT;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign word_ready    = (state_q == S_LOAD);
    assign core_reset    = (state_q != S_RUN);
    assign busy          = (state_q == S_LOAD) || (state_q == S_FLUSH) ||
                           (state_q == S_RUN);
    assign done          = (state_q == S_HALT);
    assign error         = error_q;
    assign cycle_count   = cyc_q;
    assign instr_in      = instr_q;
    assign instr_wr_addr = addr_q;
    assign instr_wr_en   = wr_en_q;

endmodule

// File: tb/tb_boot_controller.sv
// tb_boot_controller: directed stimulus with a cycle-level reference model
// and literal checks on write logs, run lengths and reset values.
module tb_boot_controller;

    localparam int SIZE = 128;
    localparam int LOGSIZE = 7;

    logic               clk = 1'b0;
    logic               reset = 1'b1;
    logic               load_start = 1'b0;
    logic [LOGSIZE:0]   load_count = '0;
    logic [31:0]        word_in = '0;
    logic               word_valid = 1'b0;
    logic               word_ready;
    logic [31:0]        run_cycles = '0;
    logic               stop = 1'b0;
    logic [31:0]        instr_in;
    logic [LOGSIZE+1:0] instr_wr_addr;
    logic               instr_wr_en;
    logic               core_reset;
    logic               busy;
    logic               done;
    logic               error;
    logic [31:0]        cycle_count;

    boot_controller #(.WIDTH(32), .SIZE(SIZE)) dut (
        .clk           (clk),
        .reset         (reset),
        .load_start    (load_start),
        .load_count    (load_count),
        .word_in       (word_in),
        .word_valid    (word_valid),
        .word_ready    (word_ready),
        .run_cycles    (run_cycles),
        .stop          (stop),
        .instr_in      (instr_in),
        .instr_wr_addr (instr_wr_addr),
        .instr_wr_en   (instr_wr_en),
        .core_reset    (core_reset),
        .busy          (busy),
        .done          (done),
        .error         (error),
        .cycle_count   (cycle_count)
    );

    initial forever #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Reference model: phase 0 idle, 1 load, 2 flush, 3 run, 4 halt.
    int          m_mode = 0;
    int          m_left = 0;
    int          m_idx = 0;
    int          m_flush = 0;
    logic [31:0] m_cc = '0;
    logic        m_err = 1'b0;
    logic        m_we = 1'b0;
    logic [31:0] m_data = '0;
    logic [8:0]  m_addr = '0;
    int          cyc_no = 0;

    task automatic model_step();
        int lc;
        cyc_no++;
        lc = int'(load_count);
        m_we = 1'b0;
        if (reset) begin
            m_mode = 0;
            m_err  = 1'b0;
            m_cc   = '0;
            m_data = '0;
            m_addr = '0;
        end else if (m_mode == 0 || m_mode == 4) begin
            if (load_start) begin
                if (lc >= 1 && lc <= SIZE) begin
                    m_mode = 1;
                    m_left = lc;
                    m_idx  = 0;
                    m_err  = 1'b0;
                end else begin
                    m_err = 1'b1;
                end
            end
        end else if (m_mode == 1) begin
            if (word_valid) begin
                m_we   = 1'b1;
                m_data = word_in;
                m_addr = 9'(m_idx * 4);
                m_idx++;
                m_left--;
                if (m_left == 0) begin
                    m_mode  = 2;
                    m_flush = 2;
                end
            end
        end else if (m_mode == 2) begin
            m_flush--;
            if (m_flush == 0) begin
                m_mode = 3;
                m_cc   = '0;
            end
        end else begin
            m_cc = m_cc + 32'd1;
            if (stop || (run_cycles != 0 && m_cc == run_cycles))
                m_mode = 4;
        end
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    int   wa[$];
    int   wd[$];
    int   wc[$];
    int   rl_cnt = 0;
    int   rl_first = -1;
    logic [31:0] first_cc = '0;

    task automatic clear_logs();
        wa.delete();
        wd.delete();
        wc.delete();
        rl_cnt = 0;
        rl_first = -1;
    endtask

    // Per-cycle comparison against the model, plus write/run logging.
    initial forever begin
        @(negedge clk);
        chk("core_reset", core_reset, m_mode != 3);
        chk("word_ready", word_ready, m_mode == 1);
        chk("busy", busy, m_mode >= 1 && m_mode <= 3);
        chk("done", done, m_mode == 4);
        chk("error", error, m_err);
        chk("cycle_count", cycle_count, m_cc);
        chk("instr_wr_en", instr_wr_en, m_we);
        chk("instr_in", instr_in, m_data);
        chk("instr_wr_addr", instr_wr_addr, m_addr);
        if (instr_wr_en === 1'b1) begin
            wa.push_back(int'(instr_wr_addr));
            wd.push_back(int'(instr_in));
            wc.push_back(cyc_no);
        end
        if (core_reset === 1'b0) begin
            if (rl_first < 0) begin
                rl_first = cyc_no;
                first_cc = cycle_count;
            end
            rl_cnt++;
        end
    end

    logic [31:0] prog [0:SIZE-1];

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic start_load(input int cnt);
        load_count = (LOGSIZE + 1)'(cnt);
        load_start = 1'b1;
        cyc(1);
        load_start = 1'b0;
    endtask

    task automatic feed(input int n, input bit gap);
        for (int i = 0; i < n; i++) begin
            if (gap) begin
                word_valid = 1'b0;
                cyc(1);
            end
            word_valid = 1'b1;
            word_in = prog[i];
            cyc(1);
        end
        word_valid = 1'b0;
    endtask

    task automatic wait_done(input int lim);
        int n;
        n = 0;
        while (done !== 1'b1 && n < lim) begin
            cyc(1);
            n++;
        end
        chk("done_reached", done, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        cyc(2);
        reset = 1'b0;
        chk("rst_core_reset", core_reset, 1);
        chk("rst_busy", busy, 0);
        cyc(1);

        // Four-word load, valid held high, bounded run of 10.
        prog[0] = 32'h00500093;
        prog[1] = 32'h00A00113;
        prog[2] = 32'h002081B3;
        prog[3] = 32'h00000013;
        clear_logs();
        run_cycles = 32'd10;
        start_load(4);
        chk("t1_ready", word_ready, 1);
        feed(4, 1'b0);
        wait_done(100);
        chk("t1_nwrites", wa.size(), 4);
        if (wa.size() == 4) begin
            chk("t1_addr0", wa[0], 0);
            chk("t1_addr1", wa[1], 4);
            chk("t1_addr2", wa[2], 8);
            chk("t1_addr3", wa[3], 12);
            chk("t1_data2", wd[2], 32'h002081B3);
            chk("t1_back2back", wc[3] - wc[0], 3);
            chk("t1_flush_gap", rl_first - wc[3], 2);
        end
        chk("t1_run_len", rl_cnt, 10);
        chk("t1_cycles", cycle_count, 10);

        // Same load with word_valid toggling.
        clear_logs();
        start_load(4);
        feed(4, 1'b1);
        wait_done(100);
        chk("t2_nwrites", wa.size(), 4);
        if (wa.size() == 4) begin
            chk("t2_addr0", wa[0], 0);
            chk("t2_addr3", wa[3], 12);
            chk("t2_spacing", wc[1] - wc[0], 2);
            chk("t2_flush_gap", rl_first - wc[3], 2);
        end
        chk("t2_run_len", rl_cnt, 10);

        // Illegal counts, then a full-depth load.
        reset = 1'b1;
        cyc(1);
        reset = 1'b0;
        clear_logs();
        start_load(0);
        chk("t3_err0", error, 1);
        chk("t3_idle0", busy, 0);
        start_load(SIZE + 1);
        chk("t3_err129", error, 1);
        chk("t3_idle129", core_reset, 1);
        cyc(2);
        chk("t3_nowrite", wa.size(), 0);
        for (int i = 0; i < SIZE; i++) prog[i] = 32'h1000_0000 + i;
        run_cycles = 32'd5;
        start_load(SIZE);
        chk("t3_err_clear", error, 0);
        feed(SIZE, 1'b0);
        wait_done(300);
        chk("t3_nwrites", wa.size(), SIZE);
        if (wa.size() == SIZE) begin
            chk("t3_last_addr", wa[SIZE-1], 508);
            chk("t3_last_data", wd[SIZE-1], 32'h1000_007F);
        end
        chk("t3_cycles", cycle_count, 5);

        // Unbounded run stopped at count 37; load_start during RUN ignored.
        clear_logs();
        prog[0] = 32'h00000013;
        run_cycles = 32'd0;
        start_load(1);
        feed(1, 1'b0);
        n = 0;
        while (core_reset !== 1'b0 && n < 20) begin
            cyc(1);
            n++;
        end
        chk("t4_running", core_reset, 0);
        n = 0;
        load_count = 8'd2;
        while (cycle_count !== 32'd37 && n < 200) begin
            load_start = (cycle_count == 32'd10);
            cyc(1);
            n++;
        end
        load_start = 1'b0;
        chk("t4_at37", cycle_count, 37);
        chk("t4_still_run", busy, 1);
        stop = 1'b1;
        cyc(1);
        stop = 1'b0;
        chk("t4_done", done, 1);
        chk("t4_cycles", cycle_count, 38);
        cyc(3);
        chk("t4_hold", cycle_count, 38);
        chk("t4_nwrites", wa.size(), 1);

        // Reset in the middle of a five-word load.
        clear_logs();
        for (int i = 0; i < 5; i++) prog[i] = 32'hA000_0000 + i;
        start_load(5);
        feed(2, 1'b0);
        word_valid = 1'b1;
        word_in = prog[2];
        reset = 1'b1;
        cyc(1);
        reset = 1'b0;
        word_valid = 1'b0;
        chk("t5_ready", word_ready, 0);
        chk("t5_wr_en", instr_wr_en, 0);
        chk("t5_instr", instr_in, 0);
        chk("t5_addr", instr_wr_addr, 0);
        chk("t5_busy", busy, 0);
        chk("t5_done", done, 0);
        chk("t5_error", error, 0);
        chk("t5_cc", cycle_count, 0);
        chk("t5_core_reset", core_reset, 1);
        cyc(3);
        chk("t5_dropped", wa.size(), 2);
        clear_logs();
        run_cycles = 32'd4;
        start_load(5);
        feed(5, 1'b0);
        wait_done(100);
        chk("t5_nwrites", wa.size(), 5);
        if (wa.size() == 5) begin
            chk("t5_first_addr", wa[0], 0);
            chk("t5_last_addr", wa[4], 16);
        end
        chk("t5_cycles", cycle_count, 4);

        // Reload from HALT: two words, three cycles.
        clear_logs();
        run_cycles = 32'd3;
        start_load(2);
        chk("t6_done_clr", done, 0);
        chk("t6_cc_held", cycle_count, 4);
        feed(2, 1'b0);
        wait_done(100);
        chk("t6_cc_start", first_cc, 0);
        chk("t6_run_len", rl_cnt, 3);
        chk("t6_cycles", cycle_count, 3);
        chk("t6_nwrites", wa.size(), 2);

        cyc(2);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
